elevator_move_controller: RTL and testbench

Consumes the pickup/destination floor pair and confirm strobe produced by the push-button input stage, and drives the car through a complete trip. The car moves to the pickup floor, opens its door, moves to the destination floor, opens its door again, and returns to idle. It owns the car position, the direction indicators, the door and arrival outputs, and the busy flag that the display and top-level logic read. Floors are one-based binary numbers 1..NUM_FLOORS on 5-bit buses.

---
 rtl/elevator_move_controller.sv | 178 +++++++++++++++++
 tb/tb_elevator_move_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_move_controller.sv
// Single-car trip controller: pickup leg, door, destination leg, door, idle.
// Define ELEVATOR_REQ_QUEUE_EN to buffer one request made while a trip is running.
module elevator_move_controller #(
  parameter int unsigned NUM_FLOORS  = 9,
  parameter int unsigned FLOOR_TICKS = 4,
  parameter int unsigned DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] current,
  input  logic [4:0] destination,
  input  logic       input_confirm,
  output logic [4:0] car_floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       busy,
  output logic       arrived,
  output logic       req_drop
);
  typedef enum logic [2:0] {IDLE, MOVE_PICK, DOOR_PICK, MOVE_DEST, DOOR_DEST} state_t;

  localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_TICKS - 1);
  localparam logic [15:0] DOOR_LAST  = 16'(DOOR_TICKS - 1);
  localparam logic [4:0]  TOP_FLOOR  = 5'(NUM_FLOORS);

  state_t      state_q, state_d;
  logic [4:0]  car_q, car_d, pick_q, pick_d, dest_q, dest_d;
  logic [15:0] tick_q, tick_d;
  logic        confirm_q, confirm_d;
  logic        rq_valid_q, rq_valid_d;
  logic [4:0]  rq_cur_q, rq_cur_d, rq_dst_q, rq_dst_d;
  logic        arrived_q, arrived_d, drop_q, drop_d;
  logic [4:0]  tgt;
  logic        req_ok;
`ifdef ELEVATOR_REQ_QUEUE_EN
  logic        pend_q, pend_d;
  logic [4:0]  pend_pick_q, pend_pick_d, pend_dest_q, pend_dest_d;
`endif

  assign tgt    = (state_q == MOVE_DEST) ? dest_q : pick_q;
  assign req_ok = (rq_cur_q != '0) && (rq_cur_q <= TOP_FLOOR) &&
                  (rq_dst_q != '0) && (rq_dst_q <= TOP_FLOOR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      car_q       <= 5'd1;
      pick_q      <= '0;
      dest_q      <= '0;
      tick_q      <= '0;
      confirm_q   <= 1'b0;
      rq_valid_q  <= 1'b0;
      rq_cur_q    <= '0;
      rq_dst_q    <= '0;
      arrived_q   <= 1'b0;
      drop_q      <= 1'b0;
`ifdef ELEVATOR_REQ_QUEUE_EN
      pend_q      <= 1'b0;
      pend_pick_q <= '0;
      pend_dest_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      car_q       <= car_d;
      pick_q      <= pick_d;
      dest_q      <= dest_d;
      tick_q      <= tick_d;
      confirm_q   <= confirm_d;
      rq_valid_q  <= rq_valid_d;
      rq_cur_q    <= rq_cur_d;
      rq_dst_q    <= rq_dst_d;
      arrived_q   <= arrived_d;
      drop_q      <= drop_d;
`ifdef ELEVATOR_REQ_QUEUE_EN
      pend_q      <= pend_d;
      pend_pick_q <= pend_pick_d;
      pend_dest_q <= pend_dest_d;
`endif
    end
  end

  // Requests are staged for one cycle, so acceptance lands on the edge after detection.
  always_comb begin
    state_d    = state_q;
    car_d      = car_q;
    pick_d     = pick_q;
    dest_d     = dest_q;
    tick_d     = tick_q + 16'd1;
    confirm_d  = input_confirm;
    rq_valid_d = input_confirm && !confirm_q;
    rq_cur_d   = current;
    rq_dst_d   = destination;
    drop_d     = 1'b0;
`ifdef ELEVATOR_REQ_QUEUE_EN
    pend_d      = pend_q;
    pend_pick_d = pend_pick_q;
    pend_dest_d = pend_dest_q;
`endif
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rq_valid_q && req_ok) begin
          pick_d  = rq_cur_q;
          dest_d  = rq_dst_q;
          state_d = MOVE_PICK;
        end
      end
      MOVE_PICK, MOVE_DEST: begin
        if (car_q == tgt) begin
          state_d = (state_q == MOVE_PICK) ? DOOR_PICK : DOOR_DEST;
          tick_d  = '0;
        end else if (tick_q == FLOOR_LAST) begin
          car_d  = (tgt > car_q) ? car_q + 5'd1 : car_q - 5'd1;
          tick_d = '0;
        end
      end
      DOOR_PICK: begin
        if (tick_q == DOOR_LAST) begin
          state_d = MOVE_DEST;
          tick_d  = '0;
        end
      end
      DOOR_DEST: begin
        if (tick_q == DOOR_LAST) begin
          state_d = IDLE;
          tick_d  = '0;
`ifdef ELEVATOR_REQ_QUEUE_EN
          if (pend_q) begin
            state_d = MOVE_PICK;
            pick_d  = pend_pick_q;
            dest_d  = pend_dest_q;
            pend_d  = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
    if (rq_valid_q) begin
      if (!req_ok) begin
        drop_d = 1'b1;
      end else if (state_q != IDLE) begin
`ifdef ELEVATOR_REQ_QUEUE_EN
        if (!pend_q) begin
          pend_d      = 1'b1;
          pend_pick_d = rq_cur_q;
          pend_dest_d = rq_dst_q;
        end else begin
          drop_d = 1'b1;
        end
`else
        drop_d = 1'b1;
`endif
      end
    end
    arrived_d = (state_d == DOOR_DEST) && (tick_d == DOOR_LAST);
  end

  always_comb begin
    moving_up   = 1'b0;
    moving_down = 1'b0;
    door_open   = state_q inside {DOOR_PICK, DOOR_DEST};
    busy        = state_q != IDLE;
    if (state_q inside {MOVE_PICK, MOVE_DEST}) begin
      moving_up   = tgt > car_q;
      moving_down = tgt < car_q;
    end
  end

  assign car_floor = car_q;
  assign arrived   = arrived_q;
  assign req_drop  = drop_q;

endmodule

// File: tb/tb_elevator_move_controller.sv
// Scoreboard bench for elevator_move_controller: stimulus queues timed output
// events, a negedge monitor detects DUT output events and compares them in order.
module tb_elevator_move_controller;
  localparam int NF = 9;
  localparam int FT = 4;
  localparam int DT = 3;

  localparam int EV_BUSY   = 0;
  localparam int EV_FLOOR  = 1;
  localparam int EV_DOOR   = 2;
  localparam int EV_DCLOSE = 3;
  localparam int EV_ARR    = 4;
  localparam int EV_DROP   = 5;
  localparam int EV_IDLE   = 6;
  localparam int UP        = 32;
  localparam int DN        = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] current = '0;
  logic [4:0] destination = '0;
  logic       input_confirm = 1'b0;
  logic [4:0] car_floor;
  logic       moving_up, moving_down, door_open, busy, arrived, req_drop;

  elevator_move_controller #(
    .NUM_FLOORS (NF),
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .current      (current),
    .destination  (destination),
    .input_confirm(input_confirm),
    .car_floor    (car_floor),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .door_open    (door_open),
    .busy         (busy),
    .arrived      (arrived),
    .req_drop     (req_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int value;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  function automatic string ev_name(input int k);
    case (k)
      EV_BUSY:   return "busy_rise";
      EV_FLOOR:  return "floor_step";
      EV_DOOR:   return "door_open_rise";
      EV_DCLOSE: return "door_close";
      EV_ARR:    return "arrived";
      EV_DROP:   return "req_drop";
      default:   return "busy_fall";
    endcase
  endfunction

  // Kept sorted by (cycle, kind) so it matches the monitor's per-cycle order.
  task automatic expect_ev(input int kind, input int value, input int at);
    ev_t e;
    int  idx;
    e.kind  = kind;
    e.value = value;
    e.at    = at;
    idx = 0;
    while (idx < exp_q.size() &&
           (exp_q[idx].at < at || (exp_q[idx].at == at && exp_q[idx].kind <= kind)))
      idx++;
    exp_q.insert(idx, e);
  endtask

  task automatic observe(input int kind, input int value);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got value=%0d at cycle %0d, required no event", ev_name(kind), value, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value || e.at != cyc) begin
        fails++;
        $display("FAIL %s: got %s value=%0d at cycle %0d, required %s value=%0d at cycle %0d",
                 ev_name(e.kind), ev_name(kind), value, cyc, ev_name(e.kind), e.value, e.at);
      end
    end
  endtask

  logic [4:0] prev_floor = 5'd1;
  logic       prev_up = 1'b0, prev_down = 1'b0, prev_door = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !prev_busy)      observe(EV_BUSY, 0);
      if (car_floor != prev_floor) observe(EV_FLOOR, int'(car_floor) + (prev_up ? UP : 0) + (prev_down ? DN : 0));
      if (door_open && !prev_door) observe(EV_DOOR, int'(car_floor));
      if (!door_open && prev_door) observe(EV_DCLOSE, int'(car_floor));
      if (arrived)                 observe(EV_ARR, int'(car_floor));
      if (req_drop)                observe(EV_DROP, 0);
      if (!busy && prev_busy)      observe(EV_IDLE, 0);
    end
    prev_floor = car_floor;
    prev_up    = moving_up;
    prev_down  = moving_down;
    prev_door  = door_open;
    prev_busy  = busy;
  end

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Expected events of a whole trip starting with the car at s, entering MOVE_PICK at cycle m.
  task automatic expect_trip(input int s, input int p, input int d, input int m,
                             input bit with_busy, input bit with_idle, output int t_end);
    int t;
    int f;
    int dir;
    t = m;
    f = s;
    if (with_busy) expect_ev(EV_BUSY, 0, t);
    while (f != p) begin
      dir = (p > f) ? UP : DN;
      f   = (p > f) ? f + 1 : f - 1;
      t  += FT;
      expect_ev(EV_FLOOR, f + dir, t);
    end
    t += 1;
    expect_ev(EV_DOOR, p, t);
    t += DT;
    expect_ev(EV_DCLOSE, p, t);
    while (f != d) begin
      dir = (d > f) ? UP : DN;
      f   = (d > f) ? f + 1 : f - 1;
      t  += FT;
      expect_ev(EV_FLOOR, f + dir, t);
    end
    t += 1;
    expect_ev(EV_DOOR, d, t);
    expect_ev(EV_ARR, d, t + DT - 1);
    t += DT;
    expect_ev(EV_DCLOSE, d, t);
    if (with_idle) expect_ev(EV_IDLE, 0, t);
    t_end = t;
  endtask

  task automatic request(input int at, input logic [4:0] cur, input logic [4:0] dst, output int c0);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
    current       = cur;
    destination   = dst;
    input_confirm = 1'b1;
    c0            = cyc;
  endtask

  task automatic release_confirm();
    @(posedge clk);
    #1;
    input_confirm = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    ev_t e;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: got no event by cycle %0d, required value=%0d at cycle %0d",
               ev_name(e.kind), cyc, e.value, e.at);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int c0, c1, c2, m, t;

  initial begin
    do_reset();
    check("reset_car_floor", int'(car_floor), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_door_open", int'(door_open), 0);
    check("reset_moving", int'({moving_up, moving_down}), 0);
    check("reset_pulses", int'({arrived, req_drop}), 0);

    // Basic trip 1 -> pickup 3 -> destination 7, expectations written out by hand.
    request(0, 5'd3, 5'd7, c0);
    m = c0 + 2;
    expect_ev(EV_BUSY,   0,      m);
    expect_ev(EV_FLOOR,  UP + 2, m + 4);
    expect_ev(EV_FLOOR,  UP + 3, m + 8);
    expect_ev(EV_DOOR,   3,      m + 9);
    expect_ev(EV_DCLOSE, 3,      m + 12);
    expect_ev(EV_FLOOR,  UP + 4, m + 16);
    expect_ev(EV_FLOOR,  UP + 5, m + 20);
    expect_ev(EV_FLOOR,  UP + 6, m + 24);
    expect_ev(EV_FLOOR,  UP + 7, m + 28);
    expect_ev(EV_DOOR,   7,      m + 29);
    expect_ev(EV_ARR,    7,      m + 31);
    expect_ev(EV_DCLOSE, 7,      m + 32);
    expect_ev(EV_IDLE,   0,      m + 32);
    release_confirm();
    drain(200);

    // Downward trip from 7: pickup 5, destination 2.
    request(0, 5'd5, 5'd2, c0);
    expect_trip(7, 5, 2, c0 + 2, 1'b1, 1'b1, t);
    release_confirm();
    drain(200);

    // Zero-distance legs: car at 2, request 2 -> 2.
    request(0, 5'd2, 5'd2, c0);
    expect_trip(2, 2, 2, c0 + 2, 1'b1, 1'b1, t);
    release_confirm();
    drain(100);

    // Invalid pickup, confirm held high for several cycles.
    request(0, 5'd0, 5'd5, c0);
    expect_ev(EV_DROP, 0, c0 + 2);
    repeat (8) @(posedge clk);
    #1;
    input_confirm = 1'b0;
    drain(50);

    // Invalid destination just above the top floor.
    request(0, 5'd3, 5'd10, c0);
    expect_ev(EV_DROP, 0, c0 + 2);
    release_confirm();
    drain(50);
    check("invalid_car_floor", int'(car_floor), 2);

    // Requests while busy: 1 -> 9 trip, then 9 -> 1 mid-trip, then a third one.
    request(0, 5'd1, 5'd9, c0);
    m = c0 + 2;
`ifdef ELEVATOR_REQ_QUEUE_EN
    expect_trip(2, 1, 9, m, 1'b1, 1'b0, t);
    expect_trip(9, 9, 1, t, 1'b0, 1'b1, c1);
`else
    expect_trip(2, 1, 9, m, 1'b1, 1'b1, t);
`endif
    release_confirm();
    request(m + 10, 5'd9, 5'd1, c1);
`ifndef ELEVATOR_REQ_QUEUE_EN
    expect_ev(EV_DROP, 0, c1 + 2);
`endif
    release_confirm();
    request(m + 20, 5'd4, 5'd6, c2);
    expect_ev(EV_DROP, 0, c2 + 2);
    release_confirm();
    drain(300);

    // Reset while travelling the destination leg at floor 4.
    do_reset();
    request(0, 5'd1, 5'd6, c0);
    m = c0 + 2;
    expect_ev(EV_BUSY,   0,      m);
    expect_ev(EV_DOOR,   1,      m + 1);
    expect_ev(EV_DCLOSE, 1,      m + 4);
    expect_ev(EV_FLOOR,  UP + 2, m + 8);
    expect_ev(EV_FLOOR,  UP + 3, m + 12);
    expect_ev(EV_FLOOR,  UP + 4, m + 16);
    release_confirm();
    while (cyc < m + 18) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_car_floor", int'(car_floor), 4);
    rst = 1'b1;
    #1;
    check("async_reset_car_floor", int'(car_floor), 1);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_door_open", int'(door_open), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    drain(10);
    check("post_reset_car_floor", int'(car_floor), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
